// File: rtl/bp_pht_update_queue_pkg.sv
// Shared fetch-unit types for the gshare predictor: PHT counter type, update entry
// and the saturating-counter helper reused by the predictors.
package bp_pht_update_queue_pkg;

  localparam int unsigned PhtIndexWidth = 10;

  typedef logic [1:0] pht_ctr_t;

  localparam pht_ctr_t PHT_COUNTER_MAX = 2'd3;

  typedef struct packed {
    logic [PhtIndexWidth-1:0] idx;
    logic                     taken;
  } pht_update_entry_t;

  function automatic pht_ctr_t pht_ctr_update(pht_ctr_t ctr, logic taken);
    if (taken) begin
      return (ctr == PHT_COUNTER_MAX) ? ctr : ctr + 2'd1;
    end
    return (ctr == '0) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_pht_update_queue_fifo.sv
// Generic circular FIFO (power-of-two depth). A push while full is dropped, even when a
// pop happens in the same cycle.
module bp_pht_update_queue_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   occupancy_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    occ_q, occ_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o      = (occ_q == DepthCnt);
    empty_o     = (occ_q == '0);
    occupancy_o = occ_q;
    data_o      = mem_q[rd_ptr_q];
    do_push     = push_i && !full_o;
    do_pop      = pop_i && !empty_o;
    wr_ptr_d    = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + (PtrW + 1)'(1);
      2'b01:   occ_d = occ_q - (PtrW + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/bp_pht_update_queue.sv
// Buffers committed branch outcomes and drains them into the gshare PHT through a
// two-stage read-modify-write pipeline with same-index forwarding.
module bp_pht_update_queue
  import bp_pht_update_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned PHT_INDEX_WIDTH = 10,
  parameter int unsigned PC_WIDTH        = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enq_valid,
  input  logic [PC_WIDTH-1:0]            enq_pc,
  input  logic [PHT_INDEX_WIDTH-1:0]     enq_history,
  input  logic                           enq_taken,
  output logic                           enq_ready,
  input  logic                           pht_grant,
  output logic                           pht_rd_en,
  output logic [PHT_INDEX_WIDTH-1:0]     pht_rd_index,
  input  logic [1:0]                     pht_rd_data,
  output logic                           pht_we,
  output logic [PHT_INDEX_WIDTH-1:0]     pht_wr_index,
  output logic [1:0]                     pht_wr_data,
  output logic [$clog2(QUEUE_DEPTH):0]   occupancy
);

  localparam int unsigned EntryW = PHT_INDEX_WIDTH + 1;

  logic [EntryW-1:0]          enq_entry, head_entry;
  logic [PHT_INDEX_WIDTH-1:0] enq_idx, head_idx;
  logic                       fifo_full, fifo_empty, issue;

  logic                       s1_valid_q, s1_valid_d;
  logic [PHT_INDEX_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic                       s1_taken_q, s1_taken_d;
  logic                       fwd_valid_q, fwd_valid_d;
  logic [PHT_INDEX_WIDTH-1:0] fwd_idx_q, fwd_idx_d;
  pht_ctr_t                   fwd_data_q, fwd_data_d;
  logic                       fwd_hit;
  pht_ctr_t                   ctr_cur, ctr_new;

  logic unused_pc;
  assign unused_pc = ^{enq_pc[PC_WIDTH-1:PHT_INDEX_WIDTH+2], enq_pc[1:0]};

  assign enq_idx   = enq_pc[PHT_INDEX_WIDTH+1:2] ^ enq_history;
  assign enq_entry = {enq_idx, enq_taken};
  assign head_idx  = head_entry[EntryW-1:1];
  assign enq_ready = !fifo_full;

  bp_pht_update_queue_fifo #(
    .Depth (QUEUE_DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (enq_valid),
    .data_i      (enq_entry),
    .pop_i       (issue),
    .data_o      (head_entry),
    .occupancy_o (occupancy),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    issue        = !fifo_empty && pht_grant;
    pht_rd_en    = issue;
    pht_rd_index = issue ? head_idx : '0;

    // The PHT read issued alongside the previous write cannot see it; take the
    // value from the forwarding register instead.
    fwd_hit      = s1_valid_q && fwd_valid_q && (fwd_idx_q == s1_idx_q);
    ctr_cur      = fwd_hit ? fwd_data_q : pht_ctr_t'(pht_rd_data);
    ctr_new      = pht_ctr_update(ctr_cur, s1_taken_q);

    pht_we       = s1_valid_q;
    pht_wr_index = s1_valid_q ? s1_idx_q : '0;
    pht_wr_data  = s1_valid_q ? ctr_new : '0;

    s1_valid_d   = issue;
    s1_idx_d     = issue ? head_idx : s1_idx_q;
    s1_taken_d   = issue ? head_entry[0] : s1_taken_q;

    // A write with no concurrent issue lands before any later read, so forwarding ends.
    fwd_valid_d  = s1_valid_q && issue;
    fwd_idx_d    = s1_valid_q ? s1_idx_q : fwd_idx_q;
    fwd_data_d   = s1_valid_q ? ctr_new : fwd_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_taken_q  <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      s1_taken_q  <= s1_taken_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_idx_q   <= fwd_idx_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_bp_pht_update_queue.sv
// Scoreboard bench: a reference PHT model predicts every read index and written counter
// at enqueue time; a negedge monitor compares whatever the DUT presents.
module tb_bp_pht_update_queue;

  localparam int unsigned Depth   = 4;
  localparam int unsigned IdxW    = 10;
  localparam int unsigned PcW     = 32;
  localparam int unsigned PhtSize = 1 << IdxW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enq_valid = 1'b0;
  logic [PcW-1:0]  enq_pc = '0;
  logic [IdxW-1:0] enq_history = '0;
  logic            enq_taken = 1'b0;
  logic            enq_ready;
  logic            pht_grant = 1'b0;
  logic            pht_rd_en;
  logic [IdxW-1:0] pht_rd_index;
  logic [1:0]      pht_rd_data = '0;
  logic            pht_we;
  logic [IdxW-1:0] pht_wr_index;
  logic [1:0]      pht_wr_data;
  logic [2:0]      occupancy;

  int total = 0;
  int bad   = 0;
  int tb_occ = 0;
  int exp_rd[$];
  int exp_wr_idx[$];
  int exp_wr_dat[$];
  int phys_pht[PhtSize];
  int model_pht[PhtSize];
  bit mem_init = 1'b0;
  bit model_init = 1'b0;

  bp_pht_update_queue #(
    .QUEUE_DEPTH     (Depth),
    .PHT_INDEX_WIDTH (IdxW),
    .PC_WIDTH        (PcW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enq_valid    (enq_valid),
    .enq_pc       (enq_pc),
    .enq_history  (enq_history),
    .enq_taken    (enq_taken),
    .enq_ready    (enq_ready),
    .pht_grant    (pht_grant),
    .pht_rd_en    (pht_rd_en),
    .pht_rd_index (pht_rd_index),
    .pht_rd_data  (pht_rd_data),
    .pht_we       (pht_we),
    .pht_wr_index (pht_wr_index),
    .pht_wr_data  (pht_wr_data),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  function automatic int hash(input logic [31:0] pc, input logic [IdxW-1:0] h);
    return int'((pc >> 2) & 32'h3FF) ^ int'(h);
  endfunction

  function automatic int sat(input int c, input logic t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // PHT array: read data returns one cycle after the request; reads see pre-write contents.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (!mem_init) begin
        for (int i = 0; i < PhtSize; i++) phys_pht[i] <= i % 4;
        mem_init <= 1'b1;
      end
    end else begin
      if (pht_rd_en) pht_rd_data <= 2'(phys_pht[pht_rd_index]);
      if (pht_we) phys_pht[pht_wr_index] <= int'(pht_wr_data);
    end
  end

  // Reference model: updates apply in commit order to an ideal counter table.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tb_occ <= 0;
      exp_rd.delete();
      exp_wr_idx.delete();
      exp_wr_dat.delete();
      if (!model_init) begin
        for (int i = 0; i < PhtSize; i++) model_pht[i] <= i % 4;
        model_init <= 1'b1;
      end else begin
        model_pht <= phys_pht;
      end
    end else begin
      if (enq_valid && tb_occ != Depth) begin
        exp_rd.push_back(hash(enq_pc, enq_history));
        exp_wr_idx.push_back(hash(enq_pc, enq_history));
        exp_wr_dat.push_back(sat(model_pht[hash(enq_pc, enq_history)], enq_taken));
        model_pht[hash(enq_pc, enq_history)] <= sat(model_pht[hash(enq_pc, enq_history)],
                                                    enq_taken);
      end
      tb_occ <= tb_occ + ((enq_valid && tb_occ != Depth) ? 1 : 0)
                       - ((tb_occ != 0 && pht_grant) ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    chk("occupancy", int'(occupancy), tb_occ);
    chk("enq_ready", int'(enq_ready), int'(tb_occ != Depth));
    chk("rd_en", int'(pht_rd_en), int'(tb_occ != 0 && pht_grant));
    if (pht_rd_en) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_index", int'(pht_rd_index), exp_rd.pop_front());
    end
    if (pht_we) begin
      if (exp_wr_idx.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        chk("wr_index", int'(pht_wr_index), exp_wr_idx.pop_front());
        chk("wr_data", int'(pht_wr_data), exp_wr_dat.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] pc, input int unsigned hist,
                       input bit t, input bit g);
    enq_valid   = v;
    enq_pc      = pc;
    enq_history = IdxW'(hist);
    enq_taken   = t;
    pht_grant   = g;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    drive(1'b1, 32'h14, 0, 1'b1, 1'b1);
    repeat (2) step();
    chk("reset_occ", int'(occupancy), 0);
    chk("reset_ready", int'(enq_ready), 1);
    chk("reset_rd_en", int'(pht_rd_en), 0);
    chk("reset_we", int'(pht_we), 0);
    chk("reset_rd_idx", int'(pht_rd_index), 0);
    chk("reset_wr_idx", int'(pht_wr_index), 0);
    chk("reset_wr_data", int'(pht_wr_data), 0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    rst = 1'b1;
    step();

    // Single update to index 5 (counter 1, taken): read at T+1, write 2 at T+2.
    drive(1'b1, 32'h14, 0, 1'b1, 1'b1);
    step();
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("single_rd_en", int'(pht_rd_en), 1);
    chk("single_rd_idx", int'(pht_rd_index), 5);
    chk("single_we_early", int'(pht_we), 0);
    step();
    @(negedge clk);
    chk("single_we", int'(pht_we), 1);
    chk("single_wr_idx", int'(pht_wr_index), 5);
    chk("single_wr_data", int'(pht_wr_data), 2);
    step();

    // Saturation at both ends.
    drive(1'b1, 32'd11 << 2, 0, 1'b1, 1'b1);
    step();
    drive(1'b1, 32'd8 << 2, 0, 1'b0, 1'b1);
    step();
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (3) step();
    chk("sat_hi", phys_pht[11], 3);
    chk("sat_lo", phys_pht[8], 0);

    // Back-to-back same index, then the same with a grant bubble before the third.
    repeat (3) begin
      drive(1'b1, 32'd9 << 2, 0, 1'b1, 1'b1);
      step();
    end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (3) step();
    chk("chain_final", phys_pht[9], 3);
    repeat (3) begin
      drive(1'b1, 32'd13 << 2, 0, 1'b1, 1'b1);
      step();
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    step();
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (3) step();
    chk("bubble_final", phys_pht[13], 3);

    // Backpressure: five offered with no grant, four accepted.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h40 + 32'(k * 4), 0, k[0], 1'b0);
      step();
    end
    @(negedge clk);
    chk("full_occ", int'(occupancy), 4);
    chk("full_ready", int'(enq_ready), 0);
    drive(1'b1, 32'h80, 0, 1'b1, 1'b1);
    step();
    @(negedge clk);
    chk("full_pop_refuse", int'(occupancy), 3);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (5) step();
    chk("drained", int'(occupancy), 0);

    // Index hash.
    drive(1'b1, 32'h0000_1010, 32'h3FF, 1'b0, 1'b1);
    step();
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("hash_idx", int'(pht_rd_index), 'h3FB);
    repeat (3) step();

    // Reset with three queued and one in S1.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h200 + 32'(k * 4), 0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    step();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk("pre_rst_we", int'(pht_we), 1);
    chk("pre_rst_occ", int'(occupancy), 3);
    #1 rst = 1'b0;
    #1;
    chk("rst_we", int'(pht_we), 0);
    chk("rst_rd_en", int'(pht_rd_en), 0);
    chk("rst_occ", int'(occupancy), 0);
    step();
    step();
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_we", int'(pht_we), 0);
    end
    step();

    // Randomised traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1023),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
      step();
    end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (10) step();
    chk("end_rd_left", exp_rd.size(), 0);
    chk("end_wr_left", exp_wr_idx.size(), 0);
    chk("end_occ", int'(occupancy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_pht_update_queue.md
Name: bp_pht_update_queue

Overview:
- Buffers resolved conditional-branch outcomes from commit and drains them, one per cycle, into the gshare pattern history table (PHT) as a read-modify-write of the 2-bit counters.
- Sits downstream of commit and upstream of the predictor's PHT write port. Predictor lookups keep priority on the shared PHT read port.
- Decouples commit bursts from PHT port availability and resolves same-index read-after-write hazards inside its own two-stage RMW pipeline.

Parameters:
- QUEUE_DEPTH, 4, number of buffered updates (power of two, >=2)
- PHT_INDEX_WIDTH, 10, PHT index bits; also the global history width
- PC_WIDTH, 32, branch PC width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- enq_valid  in  1  resolved branch update offered
- enq_pc  in  PC_WIDTH  branch PC
- enq_history  in  PHT_INDEX_WIDTH  global history used at prediction time
- enq_taken  in  1  resolved direction
- enq_ready  out  1  queue can accept this cycle
- pht_grant  in  1  PHT read port free for update use this cycle
- pht_rd_en  out  1  PHT read request
- pht_rd_index  out  PHT_INDEX_WIDTH  read index
- pht_rd_data  in  2  counter value, valid exactly one cycle after pht_rd_en
- pht_we  out  1  PHT write enable
- pht_wr_index  out  PHT_INDEX_WIDTH  write index
- pht_wr_data  out  2  new counter value
- occupancy  out  $clog2(QUEUE_DEPTH)+1  entries held in the queue (S1 excluded)

Behaviour:
- Index is computed at enqueue: idx = enq_pc[PHT_INDEX_WIDTH+1:2] XOR enq_history. The queue stores {idx, taken}.
- Enqueue: the entry is written when enq_valid && enq_ready. enq_ready = (occupancy != QUEUE_DEPTH). There is no same-cycle bypass when full, even if a dequeue happens that cycle.
- S0 (issue): when the queue is non-empty and pht_grant=1:
  - pht_rd_en=1 and pht_rd_index=head.idx;
  - the head is popped into the S1 register (s1_valid, s1_idx, s1_taken).
  - When pht_grant=0, pht_rd_en=0, there is no pop and S1 gets a bubble.
- S1 (modify/write): when s1_valid:
  - c = fwd_hit ? fwd_data : pht_rd_data;
  - pht_wr_data = s1_taken ? (c==3 ? 3 : c+1) : (c==0 ? 0 : c-1);
  - pht_we=1 and pht_wr_index=s1_idx. The outputs are combinational from S1 within the same cycle.
- Forwarding: a register pair {fwd_valid, fwd_idx, fwd_data} captures the S1 write in the cycle it occurs.
  - fwd_valid is 1 only if that write happened in the same cycle as the issue of the current S1 entry.
  - fwd_hit = s1_valid && fwd_valid && fwd_idx==s1_idx.
  - Result: back-to-back updates to one index chain correctly (e.g. 1 -> 2 -> 3, never 1 -> 2 -> 2).
  - A bubble cycle clears fwd_valid, because the PHT write has then landed before the next read.
- Latency: enqueue in cycle T, read issue earliest at T+1, write at T+2. Throughput is one update per granted cycle.
- Occupancy: +1 on enqueue, -1 on pop. Simultaneous enqueue and pop leaves it unchanged. Head and tail pointers wrap modulo QUEUE_DEPTH.
- Empty: pht_rd_en=0 regardless of pht_grant.
- Reset values (asynchronous, while rst=0):
  - pointers=0, occupancy=0, s1_valid=0, fwd_valid=0;
  - pht_rd_en=0, pht_we=0, pht_rd_index=0, pht_wr_index=0, pht_wr_data=0;
  - enq_ready=1.
- Reset mid-operation: queued and in-flight updates are discarded. No partial PHT write is issued in the reset cycle.
- There is no flush input. Updates come from committed branches only.

Decomposition:
- Shared package (FetchUnitTypes):
  - PHT_INDEX_WIDTH;
  - PHT counter typedef (2-bit, with PHT_COUNTER_MAX=3);
  - pht_update_entry_t {idx, taken};
  - a saturating-counter update function reused by the predictors.
- One natural sub-module, pht_update_fifo: a generic circular FIFO holding the entries, producing occupancy/full/empty.
- The RMW pipeline and forwarding stay in the top level.

Test Plan:
- Single update: counter=1, idx=5, taken=1, grant=1 -> rd_en at T+1 with index 5; we at T+2 with index 5 and data 2.
- Saturation: counter 3 taken -> wr_data 3; counter 0 not-taken -> wr_data 0.
- Back-to-back same index: PHT[7]=1, three taken updates enqueued on consecutive cycles -> writes 2, 3, 3 via forwarding. With a grant=0 bubble between the 2nd and 3rd, the write sequence is still 2, 3, 3.
- Full/backpressure (QUEUE_DEPTH=4): grant=0, enqueue 5 updates -> first 4 accepted, enq_ready=0, occupancy=4. Grant=1 then drains one per cycle in FIFO order. A simultaneous enqueue/pop at full is refused.
- Index hash: pc=0x0000_1010, history=0x3FF -> idx = 0x004 XOR 0x3FF = 0x3FB on pht_rd_index.
- Reset mid-op: 3 queued plus 1 in S1, assert rst -> pht_we and pht_rd_en drop immediately, occupancy=0. After release, no writes occur until a new enqueue.
